// File: rtl/wb_mem_pkg.sv
// Shared types and sizing for the Wishbone-to-word-RAM bridge.
// Latency: n/a (declarations only); backpressure: n/a.
package wb_mem_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_FETCH = 3'd1,
        RD_BEAT  = 3'd2,
        WR_BEAT  = 3'd3,
        ERR      = 3'd4
    } state_e;

    localparam int MEM_BYTES_DEF = 65536;
    localparam int MEM_WORDS     = MEM_BYTES_DEF / 4;
    localparam int WIDX_W        = $clog2(MEM_WORDS);

    function automatic int idx_width(input int mem_bytes);
        return $clog2(mem_bytes / 4);
    endfunction

endpackage

// File: rtl/wb_beat_ctr.sv
// Burst bookkeeping: remaining beat count and auto-incrementing word index (wraps at RAM size).
// Latency: load/step take effect on the next edge; backpressure: steps only when told to.
module wb_beat_ctr #(
    parameter int BL_W  = 10,
    parameter int IDX_W = 14
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [IDX_W-1:0] idx_i,
    input  logic [BL_W-1:0]  bl_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             last_o,
    output logic             done_o
);

    logic [IDX_W-1:0] idx_q, idx_d;
    logic [BL_W-1:0]  left_q, left_d;

    assign idx_o  = idx_q;
    assign last_o = (left_q == BL_W'(1));
    assign done_o = (left_q == '0);

    always_comb begin
        idx_d  = idx_q;
        left_d = left_q;
        if (load_i) begin
            idx_d  = idx_i;
            left_d = (bl_i == '0) ? BL_W'(1) : bl_i;
        end else if (step_i && !done_o) begin
            idx_d  = idx_q + IDX_W'(1);
            left_d = left_q - BL_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= '0;
            left_q <= '0;
        end else begin
            idx_q  <= idx_d;
            left_q <= left_d;
        end
    end

endmodule

// File: rtl/wb_mem_bridge.sv
// Wishbone burst slave onto a 1-cycle-latency byte-enable word RAM, with lack and error responses.
// Latency: write ack 1 cycle after request, read ack 2 cycles; backpressure: read beats wait for bry_i.
module wb_mem_bridge
    import wb_mem_pkg::*;
#(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int BL_W      = 10,
    parameter int MEM_BYTES = MEM_BYTES_DEF
) (
    input  logic            clk_i,
    input  logic            rst_n,
    input  logic [AW-1:0]   s_wbd_adr_i,
    input  logic [DW-1:0]   s_wbd_dat_i,
    input  logic [3:0]      s_wbd_sel_i,
    input  logic [BL_W-1:0] s_wbd_bl_i,
    input  logic            s_wbd_bry_i,
    input  logic            s_wbd_we_i,
    input  logic            s_wbd_cyc_i,
    input  logic            s_wbd_stb_i,
    output logic [DW-1:0]   s_wbd_dat_o,
    output logic            s_wbd_ack_o,
    output logic            s_wbd_lack_o,
    output logic            s_wbd_err_o,
    output logic [AW-3:0]   mem_raddr_o,
    input  logic [DW-1:0]   mem_dout_i,
    output logic [AW-3:0]   mem_waddr_o,
    output logic [DW-1:0]   mem_din_o,
    output logic [3:0]      mem_we_o
);

    localparam int IDX_W = idx_width(MEM_BYTES);

    state_e          state_q, state_d;
    logic            ack_q, ack_d;
    logic            lack_q, lack_d;
    logic            single_q, single_d;
    logic [DW-1:0]   dat_q, dat_d;

    logic            ctr_load, ctr_step;
    logic [IDX_W-1:0] beat_idx, raddr_idx;
    logic            beats_last, beats_done;
    logic            adr_bad;

    // Anything above the RAM window or not word aligned is rejected up front.
    assign adr_bad = (|s_wbd_adr_i[1:0]) | (|(s_wbd_adr_i >> (IDX_W + 2)));

    wb_beat_ctr #(
        .BL_W  (BL_W),
        .IDX_W (IDX_W)
    ) u_beat_ctr (
        .clk_i  (clk_i),
        .rst_n  (rst_n),
        .load_i (ctr_load),
        .step_i (ctr_step),
        .idx_i  (s_wbd_adr_i[IDX_W+1:2]),
        .bl_i   (s_wbd_bl_i),
        .idx_o  (beat_idx),
        .last_o (beats_last),
        .done_o (beats_done)
    );

    assign s_wbd_dat_o  = dat_q;
    assign s_wbd_ack_o  = ack_q & s_wbd_cyc_i;
    assign s_wbd_lack_o = lack_q & s_wbd_cyc_i;
    assign s_wbd_err_o  = (state_q == ERR) & s_wbd_cyc_i;
    assign mem_raddr_o  = (AW-2)'(raddr_idx);
    assign mem_waddr_o  = (AW-2)'(beat_idx);
    assign mem_din_o    = s_wbd_dat_i;

    always_comb begin
        state_d   = state_q;
        ack_d     = 1'b0;
        lack_d    = 1'b0;
        dat_d     = dat_q;
        single_d  = single_q;
        ctr_load  = 1'b0;
        ctr_step  = 1'b0;
        raddr_idx = beat_idx;
        mem_we_o  = 4'b0000;
        case (state_q)
            IDLE: begin
                if (s_wbd_cyc_i && s_wbd_stb_i) begin
                    ctr_load = 1'b1;
                    single_d = (s_wbd_bl_i <= BL_W'(1));
                    if (adr_bad)         state_d = ERR;
                    else if (s_wbd_we_i) state_d = WR_BEAT;
                    else                 state_d = RD_FETCH;
                end
            end
            ERR: state_d = IDLE;
            RD_FETCH: state_d = s_wbd_cyc_i ? RD_BEAT : IDLE;
            RD_BEAT: begin
                if (!s_wbd_cyc_i || beats_done) begin
                    state_d = IDLE;
                end else if (single_q || s_wbd_bry_i) begin
                    // Issuing a beat already points the RAM at the next word so beats can stream.
                    ack_d     = 1'b1;
                    lack_d    = beats_last;
                    dat_d     = mem_dout_i;
                    ctr_step  = 1'b1;
                    raddr_idx = beat_idx + IDX_W'(1);
                end
            end
            WR_BEAT: begin
                if (!s_wbd_cyc_i || beats_done) begin
                    state_d = IDLE;
                end else if (s_wbd_stb_i && !ack_q) begin
                    mem_we_o = s_wbd_sel_i;
                    ack_d    = 1'b1;
                    lack_d   = beats_last;
                    ctr_step = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ack_q    <= 1'b0;
            lack_q   <= 1'b0;
            single_q <= 1'b0;
            dat_q    <= '0;
        end else begin
            state_q  <= state_d;
            ack_q    <= ack_d;
            lack_q   <= lack_d;
            single_q <= single_d;
            dat_q    <= dat_d;
        end
    end

endmodule

// File: tb/tb_wb_mem_bridge.sv
// Randomized bench for wb_mem_bridge: bus master tasks, a behavioural RAM and a word-level reference memory.
// Latency: checks 1-cycle write / 2-cycle read acks; backpressure: drives bry_i fixed, stalled and random.
module tb_wb_mem_bridge;

    localparam int AW        = 32;
    localparam int DW        = 32;
    localparam int BL_W      = 10;
    localparam int MEM_BYTES = 65536;
    localparam int WORDS     = MEM_BYTES / 4;

    logic            clk_i = 1'b0;
    logic            rst_n = 1'b0;
    logic [AW-1:0]   adr   = '0;
    logic [DW-1:0]   wdat  = '0;
    logic [3:0]      sel   = '0;
    logic [BL_W-1:0] bl    = '0;
    logic            bry   = 1'b0;
    logic            we    = 1'b0;
    logic            cyc   = 1'b0;
    logic            stb   = 1'b0;
    logic [DW-1:0]   rdat;
    logic            ack, lack, err;
    logic [AW-3:0]   raddr, waddr;
    logic [DW-1:0]   mem_dout, mem_din;
    logic [3:0]      mem_we;

    logic [31:0] ram     [WORDS];
    logic [31:0] ref_mem [WORDS];
    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk_i = ~clk_i;

    wb_mem_bridge #(.AW(AW), .DW(DW), .BL_W(BL_W), .MEM_BYTES(MEM_BYTES)) dut (
        .clk_i        (clk_i),
        .rst_n        (rst_n),
        .s_wbd_adr_i  (adr),
        .s_wbd_dat_i  (wdat),
        .s_wbd_sel_i  (sel),
        .s_wbd_bl_i   (bl),
        .s_wbd_bry_i  (bry),
        .s_wbd_we_i   (we),
        .s_wbd_cyc_i  (cyc),
        .s_wbd_stb_i  (stb),
        .s_wbd_dat_o  (rdat),
        .s_wbd_ack_o  (ack),
        .s_wbd_lack_o (lack),
        .s_wbd_err_o  (err),
        .mem_raddr_o  (raddr),
        .mem_dout_i   (mem_dout),
        .mem_waddr_o  (waddr),
        .mem_din_o    (mem_din),
        .mem_we_o     (mem_we)
    );

    // Synchronous word RAM: byte-enable write, registered read.
    always @(posedge clk_i) begin
        for (int b = 0; b < 4; b++)
            if (mem_we[b]) ram[waddr[13:0]][8*b +: 8] <= mem_din[8*b +: 8];
        mem_dout <= ram[raddr[13:0]];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    task automatic bus_idle();
        cyc = 1'b0; stb = 1'b0; we = 1'b0; bry = 1'b0; sel = 4'h0;
    endtask

    // Write burst; incr=1 gives data d0+i with full selects, else random data/selects after beat 0.
    task automatic do_write(input logic [31:0] a, input int blv, input int abort_after,
                            input logic [31:0] d0, input logic [3:0] s0, input bit incr);
        int nb  = (blv == 0) ? 1 : blv;
        int w0  = int'(a[15:2]);
        int got = 0;
        int k   = 0;
        adr = a; bl = BL_W'(blv); we = 1'b1; cyc = 1'b1; stb = 1'b1; wdat = d0; sel = s0;
        while (got < nb) begin
            tick(); k++;
            chk("wr_we", 32'(mem_we), (k % 2 == 1) ? 32'(sel) : 32'h0);
            if (k % 2 == 1) chk("wr_waddr", 32'(waddr), 32'((w0 + got) % WORDS));
            chk("wr_ack", 32'(ack), 32'(k % 2 == 0));
            chk("wr_lack", 32'(lack), 32'((k % 2 == 0) && (got == nb - 1)));
            if (k % 2 == 0) begin
                ref_mem[(w0 + got) % WORDS] = merge(ref_mem[(w0 + got) % WORDS], wdat, sel);
                got++;
                if (abort_after > 0 && got == abort_after) break;
                wdat = incr ? d0 + 32'(got) : $urandom;
                sel  = incr ? 4'hf : 4'($urandom);
            end
        end
        bus_idle();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("wr_after_ack", 32'(ack), 32'h0);
            chk("wr_after_we", 32'(mem_we), 32'h0);
        end
        for (int i = 0; i < nb; i++)
            chk("wr_ram", ram[(w0 + i) % WORDS], ref_mem[(w0 + i) % WORDS]);
    endtask

    // Read burst; mode 0: bry high, 1: random bry, 2: bry low for 3 cycles once 3 beats are in.
    task automatic do_read(input logic [31:0] a, input int blv, input int mode);
        int nb    = (blv == 0) ? 1 : blv;
        int w0    = int'(a[15:2]);
        int got   = 0;
        int k     = 0;
        int stall = 0;
        logic        exp_ack;
        logic        bry_prev;
        logic [31:0] last_d = '0;
        adr = a; bl = BL_W'(blv); we = 1'b0; cyc = 1'b1; stb = 1'b1;
        bry = (mode == 1) ? 1'($urandom) : 1'b1;
        bry_prev = bry;
        while (got < nb && k < 300) begin
            tick(); k++;
            exp_ack = (k >= 3) && (nb == 1 || bry_prev);
            chk("rd_ack", 32'(ack), 32'(exp_ack));
            chk("rd_lack", 32'(lack), 32'(exp_ack && got == nb - 1));
            chk("rd_we", 32'(mem_we), 32'h0);
            if (exp_ack) begin
                last_d = ref_mem[(w0 + got) % WORDS];
                chk("rd_dat", rdat, last_d);
                got++;
            end else if (got > 0) begin
                chk("rd_hold", rdat, last_d);
            end
            if (mode == 0)                    bry = 1'b1;
            else if (mode == 1)               bry = ($urandom_range(0, 3) != 0);
            else if (got >= 3 && stall < 3) begin bry = 1'b0; stall++; end
            else                              bry = 1'b1;
            bry_prev = bry;
        end
        if (got < nb) chk("rd_timeout", 32'(got), 32'(nb));
        bus_idle();
        tick();
        chk("rd_after_ack", 32'(ack), 32'h0);
    endtask

    // Bad request held for three cycles: error, idle re-evaluation, error again.
    task automatic do_err(input logic [31:0] a, input logic w);
        adr = a; we = w; cyc = 1'b1; stb = 1'b1; bl = BL_W'(1); sel = 4'hf; wdat = $urandom;
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk("err_o", 32'(err), 32'(k != 2));
            chk("err_ack", 32'(ack), 32'h0);
            chk("err_we", 32'(mem_we), 32'h0);
        end
        bus_idle();
        tick();
        chk("err_end", 32'(err), 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r, widx, blv;
        for (int i = 0; i < WORDS; i++) ref_mem[i] = '0;

        #12;
        chk("rst_ack", 32'(ack), 32'h0);
        chk("rst_lack", 32'(lack), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_dat", rdat, 32'h0);
        chk("rst_we", 32'(mem_we), 32'h0);
        rst_n = 1'b1;
        tick();

        // Byte-select write over a known word, then read it back.
        do_write(32'h100, 1, 0, 32'h1122_3344, 4'hf, 1'b1);
        do_write(32'h100, 1, 0, 32'hDEAD_BEEF, 4'b0011, 1'b0);
        do_read(32'h100, 1, 0);

        // Streaming and stalled read bursts.
        do_write(32'h200, 4, 0, 32'h0000_00A0, 4'hf, 1'b1);
        do_read(32'h200, 4, 0);
        do_read(32'h200, 4, 2);

        do_err(32'h0001_0000, 1'b1);
        do_err(32'h0000_0102, 1'b0);

        // Working regions, including one that wraps past the top of RAM.
        do_write(32'h1000, 64, 0, 32'h5000_0000, 4'hf, 1'b1);
        do_write(MEM_BYTES - 16, 12, 0, 32'h7700_0000, 4'hf, 1'b1);
        do_read(MEM_BYTES - 8, 5, 0);

        // Write burst abandoned after two acks.
        do_write(32'h1040, 4, 2, 32'hC0DE_0000, 4'hf, 1'b0);
        do_read(32'h1040, 4, 0);

        // Asynchronous reset in the middle of a read burst.
        adr = 32'h200; bl = BL_W'(4); we = 1'b0; bry = 1'b1; cyc = 1'b1; stb = 1'b1;
        tick(); tick(); tick();
        chk("arst_pre_ack", 32'(ack), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ack", 32'(ack), 32'h0);
        chk("arst_lack", 32'(lack), 32'h0);
        chk("arst_err", 32'(err), 32'h0);
        chk("arst_dat", rdat, 32'h0);
        bus_idle();
        #2 rst_n = 1'b1;
        tick();
        chk("arst_idle_ack", 32'(ack), 32'h0);
        do_read(32'h200, 1, 0);

        for (int t = 0; t < 40; t++) begin
            r    = $urandom_range(0, 9);
            blv  = $urandom_range(0, 6);
            widx = ($urandom_range(0, 3) == 0) ? WORDS - 1 - $urandom_range(0, 2)
                                               : 32'h400 + $urandom_range(0, 57);
            if (r == 0) begin
                if ($urandom_range(0, 1) == 0) do_err(32'(widx * 4) | 32'($urandom_range(1, 3)), 1'($urandom));
                else                           do_err(32'(MEM_BYTES) + 32'($urandom_range(0, 4095) * 4), 1'($urandom));
            end else if (r < 5) begin
                do_write(32'(widx * 4), blv, 0, $urandom, 4'($urandom), 1'b0);
            end else begin
                do_read(32'(widx * 4), blv, 1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
